// File: rtl/io_timer_pkg.sv
// Shared register offsets, CTRL bit positions and timer state encoding for the OTTER IO timer.
// No logic, so no latency; no backpressure.
package io_timer_pkg;

  localparam logic [4:0] OFS_CTRL     = 5'h00;
  localparam logic [4:0] OFS_PRESCALE = 5'h04;
  localparam logic [4:0] OFS_RELOAD   = 5'h08;
  localparam logic [4:0] OFS_COUNT    = 5'h0C;
  localparam logic [4:0] OFS_STATUS   = 5'h10;
  localparam logic [4:0] OFS_WDOG     = 5'h14;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IRQ  = 2;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_t;

endpackage

// File: rtl/io_prescaler.sv
// Cycle divider: tick pulses once every limit+1 enabled cycles.
// Combinational tick from the count register; no backpressure, clr/!en hold the count at 0.
module io_prescaler #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         tick
);

  localparam logic [W-1:0] ONE = 1;

  logic [W-1:0] cnt;

  // >= rather than == so a limit lowered mid-count still wraps promptly
  assign tick = en && (cnt >= limit);

  always_ff @(posedge CLK) begin
    if (RESET || clr || !en || tick) cnt <= '0;
    else                             cnt <= cnt + ONE;
  end

endmodule

// File: rtl/otter_io_timer.sv
// OTTER IOBUS down-counting timer with pending interrupt; optional watchdog under OTTER_TIMER_WDOG_EN.
// Reads return one cycle after the address (write-through); INTR is combinational; IOBUS never stalls.
module otter_io_timer #(
  parameter logic [31:0] BASE_ADDR  = 32'h1100_0100,
  parameter int          PRESCALE_W = 16,
  parameter logic [31:0] WDOG_TICKS = 32'd1_000_000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        INTR,
  output logic        WDOG_RST
);

  import io_timer_pkg::*;

  localparam logic [31:0] ONE32 = 32'd1;

  timer_state_t state, state_nxt;
  logic                  en_q, en_nxt, auto_q, auto_nxt, irq_q, irq_nxt, pend_q, pend_nxt;
  logic [PRESCALE_W-1:0] prescale_q, prescale_nxt;
  logic [31:0]           reload_q, reload_nxt, count_q, count_nxt;
  logic [31:0]           rd_nxt, wdog_rd;
  logic                  hit, wr_ctrl, wr_prescale, wr_reload, wr_count, wr_status;
  logic                  run, tick, expire;
  logic [4:0]            ofs;

  assign hit         = (IOBUS_ADDR[31:5] == BASE_ADDR[31:5]);
  assign ofs         = IOBUS_ADDR[4:0];
  assign wr_ctrl     = IOBUS_WR && hit && (ofs == OFS_CTRL);
  assign wr_prescale = IOBUS_WR && hit && (ofs == OFS_PRESCALE);
  assign wr_reload   = IOBUS_WR && hit && (ofs == OFS_RELOAD);
  assign wr_count    = IOBUS_WR && hit && (ofs == OFS_COUNT);
  assign wr_status   = IOBUS_WR && hit && (ofs == OFS_STATUS);

  assign run    = (state == RUN);
  assign expire = tick && (count_q == '0);

  io_prescaler #(.W(PRESCALE_W)) u_prescaler (
    .CLK   (CLK),
    .RESET (RESET),
    .clr   (wr_count),
    .en    (run),
    .limit (prescale_q),
    .tick  (tick)
  );

  always_comb begin
    state_nxt    = state;
    en_nxt       = en_q;
    auto_nxt     = auto_q;
    irq_nxt      = irq_q;
    pend_nxt     = pend_q;
    prescale_nxt = prescale_q;
    reload_nxt   = reload_q;
    count_nxt    = count_q;

    case (state)
      STOP:    if (wr_ctrl && IOBUS_OUT[CTRL_EN]) state_nxt = RUN;
      RUN: begin
        if (wr_ctrl)                 state_nxt = IOBUS_OUT[CTRL_EN] ? RUN : STOP;
        else if (expire && !auto_q)  state_nxt = DONE;
      end
      DONE:    state_nxt = (wr_ctrl && IOBUS_OUT[CTRL_EN]) ? RUN : STOP;
      default: state_nxt = STOP;
    endcase

    // An explicit CTRL write overrides the one-shot auto-clear of EN
    if (wr_ctrl) begin
      en_nxt   = IOBUS_OUT[CTRL_EN];
      auto_nxt = IOBUS_OUT[CTRL_AUTO];
      irq_nxt  = IOBUS_OUT[CTRL_IRQ];
    end else if (expire && !auto_q) begin
      en_nxt = 1'b0;
    end

    if (wr_prescale) prescale_nxt = IOBUS_OUT[PRESCALE_W-1:0];
    if (wr_reload)   reload_nxt   = IOBUS_OUT;

    if (wr_count)                count_nxt = IOBUS_OUT;
    else if (expire && auto_q)   count_nxt = reload_q;
    else if (tick && !expire)    count_nxt = count_q - ONE32;

    if (expire)                           pend_nxt = 1'b1;
    else if (wr_status && IOBUS_OUT[0])   pend_nxt = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= STOP;
      en_q       <= 1'b0;
      auto_q     <= 1'b0;
      irq_q      <= 1'b0;
      pend_q     <= 1'b0;
      prescale_q <= '0;
      reload_q   <= '0;
      count_q    <= '0;
    end else begin
      state      <= state_nxt;
      en_q       <= en_nxt;
      auto_q     <= auto_nxt;
      irq_q      <= irq_nxt;
      pend_q     <= pend_nxt;
      prescale_q <= prescale_nxt;
      reload_q   <= reload_nxt;
      count_q    <= count_nxt;
    end
  end

`ifdef OTTER_TIMER_WDOG_EN
  logic [31:0] wdog_cnt, wdog_cnt_nxt;
  logic        wdog_armed, wdog_armed_nxt, wdog_rst_q, wdog_rst_nxt;
  logic        wr_wdog;

  assign wr_wdog = IOBUS_WR && hit && (ofs == OFS_WDOG);

  // A kick in the expiry cycle reloads and suppresses the pulse
  always_comb begin
    wdog_cnt_nxt   = wdog_cnt;
    wdog_armed_nxt = wdog_armed;
    wdog_rst_nxt   = 1'b0;
    if (wr_wdog) begin
      wdog_cnt_nxt   = WDOG_TICKS;
      wdog_armed_nxt = 1'b1;
    end else if (wdog_armed) begin
      if (wdog_cnt <= ONE32) begin
        wdog_cnt_nxt   = '0;
        wdog_armed_nxt = 1'b0;
        wdog_rst_nxt   = 1'b1;
      end else begin
        wdog_cnt_nxt = wdog_cnt - ONE32;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wdog_cnt   <= '0;
      wdog_armed <= 1'b0;
      wdog_rst_q <= 1'b0;
    end else begin
      wdog_cnt   <= wdog_cnt_nxt;
      wdog_armed <= wdog_armed_nxt;
      wdog_rst_q <= wdog_rst_nxt;
    end
  end

  assign wdog_rd  = wdog_cnt_nxt;
  assign WDOG_RST = wdog_rst_q;
`else
  assign wdog_rd  = '0;
  assign WDOG_RST = 1'b0;
`endif

  // Read mux uses next-state values so a same-edge write is visible
  always_comb begin
    rd_nxt = '0;
    if (hit) begin
      case (ofs)
        OFS_CTRL:     rd_nxt = {29'd0, irq_nxt, auto_nxt, en_nxt};
        OFS_PRESCALE: rd_nxt = 32'(prescale_nxt);
        OFS_RELOAD:   rd_nxt = reload_nxt;
        OFS_COUNT:    rd_nxt = count_nxt;
        OFS_STATUS:   rd_nxt = {31'd0, pend_nxt};
        OFS_WDOG:     rd_nxt = wdog_rd;
        default:      rd_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) IOBUS_IN <= '0;
    else       IOBUS_IN <= rd_nxt;
  end

  assign INTR = pend_q & irq_q;

endmodule

// File: tb/tb_otter_io_timer.sv
// Directed self-checking bench for otter_io_timer; watchdog steps run only with OTTER_TIMER_WDOG_EN.
module tb_otter_io_timer;

  localparam logic [31:0] B = 32'h1100_0100;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] IOBUS_ADDR, IOBUS_OUT, IOBUS_IN;
  logic        IOBUS_WR, INTR, WDOG_RST;

  int checks = 0;
  int errors = 0;
  logic [31:0] rv;

  otter_io_timer #(
    .BASE_ADDR  (B),
    .PRESCALE_W (16),
    .WDOG_TICKS (32'd8)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .IOBUS_ADDR (IOBUS_ADDR),
    .IOBUS_OUT  (IOBUS_OUT),
    .IOBUS_WR   (IOBUS_WR),
    .IOBUS_IN   (IOBUS_IN),
    .INTR       (INTR),
    .WDOG_RST   (WDOG_RST)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    IOBUS_ADDR = a; IOBUS_OUT = d; IOBUS_WR = 1'b1;
    @(negedge CLK);
    IOBUS_WR = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    IOBUS_ADDR = a;
    @(negedge CLK);
    d = IOBUS_IN;
  endtask

  initial begin
    logic [31:0] exp_cnt [6];
    logic        exp_irq [6];
    exp_cnt = '{32'd2, 32'd1, 32'd1, 32'd0, 32'd0, 32'd2};
    exp_irq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    RESET = 1'b1; IOBUS_ADDR = '0; IOBUS_OUT = '0; IOBUS_WR = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    check("por_iobus_in", IOBUS_IN, 32'h0);
    check("por_intr", {31'd0, INTR}, 32'h0);
    check("por_wdog_rst", {31'd0, WDOG_RST}, 32'h0);

    // Readback latency and decode
    wr(B + 32'h08, 32'hDEAD_BEEF);
    check("reload_same_edge", IOBUS_IN, 32'hDEAD_BEEF);
    rd(B + 32'h08, rv);             check("reload_read", rv, 32'hDEAD_BEEF);
    rd(32'h1100_0200, rv);          check("outside_window", rv, 32'h0);
    wr(B + 32'h04, 32'hFFFF_1234);
    rd(B + 32'h04, rv);             check("prescale_width", rv, 32'h0000_1234);
    wr(B + 32'h00, 32'hFFFF_FFF8);
    rd(B + 32'h00, rv);             check("ctrl_upper_bits", rv, 32'h0);
    wr(B + 32'h18, 32'h1234_5678);
    rd(B + 32'h18, rv);             check("unmapped_offset", rv, 32'h0);
`ifndef OTTER_TIMER_WDOG_EN
    wr(B + 32'h14, 32'hFFFF_FFFF);
    rd(B + 32'h14, rv);             check("wdog_absent_read", rv, 32'h0);
    check("wdog_absent_pin", {31'd0, WDOG_RST}, 32'h0);
`endif

    // One-shot: four ticks after enable, EN self-clears
    wr(B + 32'h04, 32'd0);
    wr(B + 32'h0C, 32'd3);
    wr(B + 32'h00, 32'h5);
    rd(B + 32'h0C, rv);             check("oneshot_cnt2", rv, 32'd2);
    rd(B + 32'h0C, rv);             check("oneshot_cnt1", rv, 32'd1);
    rd(B + 32'h0C, rv);             check("oneshot_cnt0", rv, 32'd0);
    check("oneshot_intr_early", {31'd0, INTR}, 32'h0);
    rd(B + 32'h00, rv);             check("oneshot_ctrl_en0", rv, 32'h4);
    check("oneshot_intr", {31'd0, INTR}, 32'h1);
    rd(B + 32'h10, rv);             check("oneshot_pend", rv, 32'h1);
    wr(B + 32'h10, 32'h0);
    check("status_w0_noeffect", IOBUS_IN, 32'h1);
    wr(B + 32'h10, 32'h1);
    check("status_w1_clear", IOBUS_IN, 32'h0);
    check("status_clear_intr", {31'd0, INTR}, 32'h0);

    // Auto-reload, tick every 2 cycles, expiry every 6
    wr(B + 32'h04, 32'd1);
    wr(B + 32'h08, 32'd2);
    wr(B + 32'h0C, 32'd2);
    wr(B + 32'h00, 32'h7);
    for (int i = 0; i < 6; i++) begin
      rd(B + 32'h0C, rv);
      check($sformatf("auto_cnt[%0d]", i), rv, exp_cnt[i]);
      check($sformatf("auto_intr[%0d]", i), {31'd0, INTR}, {31'd0, exp_irq[i]});
    end
    wr(B + 32'h10, 32'h1);
    check("auto_clear", {31'd0, INTR}, 32'h0);
    for (int i = 1; i < 5; i++) begin
      rd(B + 32'h0C, rv);
      check($sformatf("auto2_cnt[%0d]", i), rv, exp_cnt[i]);
    end
    check("auto2_intr_low", {31'd0, INTR}, 32'h0);
    // Clear collides with expiry: set wins
    wr(B + 32'h10, 32'h1);
    check("clr_vs_set_status", IOBUS_IN, 32'h1);
    check("clr_vs_set_intr", {31'd0, INTR}, 32'h1);
    wr(B + 32'h10, 32'h1);
    check("later_clear", IOBUS_IN, 32'h0);
    for (int i = 1; i < 5; i++) begin
      rd(B + 32'h0C, rv);
      check($sformatf("auto3_cnt[%0d]", i), rv, exp_cnt[i]);
    end
    // EN=0 write collides with expiry: PEND set, timer stops
    wr(B + 32'h00, 32'h6);
    check("en0_vs_expire_ctrl", IOBUS_IN, 32'h6);
    check("en0_vs_expire_intr", {31'd0, INTR}, 32'h1);
    repeat (3) rd(B + 32'h0C, rv);
    check("stopped_count_held", rv, 32'd2);
    wr(B + 32'h10, 32'h1);

    // COUNT write beats a same-cycle tick
    wr(B + 32'h04, 32'd0);
    wr(B + 32'h00, 32'h1);
    wr(B + 32'h0C, 32'd10);
    check("count_write_wins", IOBUS_IN, 32'd10);
    rd(B + 32'h0C, rv);             check("count_after_write", rv, 32'd9);

    // Reset mid-run
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    check("rst_iobus_in", IOBUS_IN, 32'h0);
    check("rst_intr", {31'd0, INTR}, 32'h0);
    rd(B + 32'h0C, rv);             check("rst_count", rv, 32'h0);
    rd(B + 32'h00, rv);             check("rst_ctrl", rv, 32'h0);
    rd(B + 32'h08, rv);             check("rst_reload", rv, 32'h0);
    wr(B + 32'h0C, 32'd1);
    repeat (3) rd(B + 32'h0C, rv);
    check("rst_state_stop", rv, 32'd1);

`ifdef OTTER_TIMER_WDOG_EN
    wr(B + 32'h14, 32'h0);
    check("wdog_kick_read", IOBUS_IN, 32'd8);
    for (int i = 1; i <= 9; i++) begin
      @(negedge CLK);
      check($sformatf("wdog_pulse[%0d]", i), {31'd0, WDOG_RST}, (i == 8) ? 32'h1 : 32'h0);
    end
    for (int k = 0; k < 4; k++) begin
      wr(B + 32'h14, 32'h0);
      for (int i = 0; i < 4; i++) begin
        @(negedge CLK);
        check($sformatf("wdog_kept[%0d]", k), {31'd0, WDOG_RST}, 32'h0);
      end
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
